// File: rtl/display_timing_pkg.sv
// display_timing_pkg
//   Timing constants shared by the display transmit and capture blocks,
//   the capture FSM state encoding, and the frame-buffer address width
//   derivation.
package display_timing_pkg;

    localparam int DEF_H_TOTAL  = 801;
    localparam int DEF_H_START  = 16;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_TOTAL  = 601;
    localparam int DEF_V_START  = 2;
    localparam int DEF_V_ACTIVE = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEEK    = 2'd1,
        CAPTURE = 2'd2
    } cap_state_e;

    // Width needed to address h_active*v_active words (at least 1 bit).
    function automatic int addr_width(input int h_active, input int v_active);
        int words;
        words = h_active * v_active;
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    localparam int DEF_ADDR_W = addr_width(DEF_H_ACTIVE, DEF_V_ACTIVE);

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect
//   Registers the sync pins and the pixel bus once, and flags the rising
//   edges of hsync/vsync. The pixel bus is delayed by the same single stage
//   so pix_d1 is the pixel belonging to the sample that raised hs_rise.
// Ports:
//   clk, rst_n        pixel clock, async active-low reset
//   hsync, vsync      sync pins (active high)
//   pix               {r,g,b} pins
//   pix_d1            pixel bus after one register stage
//   hs_rise, vs_rise  first high sample of hsync / vsync (aligned to pix_d1)
module sync_edge_detect (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [23:0] pix,
    output logic [23:0] pix_d1,
    output logic        hs_rise,
    output logic        vs_rise
);

    logic hs_d1, hs_d2, vs_d1, vs_d2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_d1  <= 1'b0;
            hs_d2  <= 1'b0;
            vs_d1  <= 1'b0;
            vs_d2  <= 1'b0;
            pix_d1 <= '0;
        end else begin
            hs_d1  <= hsync;
            hs_d2  <= hs_d1;
            vs_d1  <= vsync;
            vs_d2  <= vs_d1;
            pix_d1 <= pix;
        end
    end

    assign hs_rise = hs_d1 & ~hs_d2;
    assign vs_rise = vs_d1 & ~vs_d2;

endmodule

// File: rtl/display_capture.sv
// display_capture
//   Receive side of the display timing interface. Locks to the incoming
//   frame timing, checks line and frame lengths, and writes the active
//   pixel window into a frame buffer as a linear address stream.
// Ports:
//   clk, rst_n             pixel clock, async active-low reset
//   enable                 capture request, acted on at frame boundaries
//   err_clr                clears line_err / frame_err / overflow
//   hsync, vsync, r, g, b  display pins from the transmitter
//   fb_wr_valid/ready      frame-buffer write handshake
//   fb_wr_addr, fb_wr_data line*H_ACTIVE+pixel, {r,g,b}
//   locked                 high while capturing
//   frame_done             one-cycle pulse after a clean frame is written
//   line_err, frame_err    sticky geometry errors
//   overflow               sticky: a pixel was dropped
// Handshake: a word transfers on a cycle where fb_wr_valid and fb_wr_ready
//   are both high. Video cannot stall, so valid is never held: a valid cycle
//   without ready drops that pixel and the address still advances.
module display_capture
    import display_timing_pkg::*;
#(
    parameter int H_TOTAL  = DEF_H_TOTAL,
    parameter int H_START  = DEF_H_START,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_TOTAL  = DEF_V_TOTAL,
    parameter int V_START  = DEF_V_START,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int ADDR_W   = addr_width(H_ACTIVE, V_ACTIVE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              err_clr,
    input  logic              hsync,
    input  logic              vsync,
    input  logic [7:0]        r,
    input  logic [7:0]        g,
    input  logic [7:0]        b,
    output logic              fb_wr_valid,
    input  logic              fb_wr_ready,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [23:0]       fb_wr_data,
    output logic              locked,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err,
    output logic              overflow
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);

    logic [23:0]       pix_d1;
    logic              hs_rise, vs_rise;
    logic [HW-1:0]     h_cnt_q, h_cnt;
    logic [VW-1:0]     v_cnt_q, v_cnt;
    logic [ADDR_W-1:0] addr_q;
    cap_state_e        state_q, state_d;
    logic              frame_bad_q;
    logic              frame_start, line_err_evt, frame_err_evt, done_evt;
    logic              line_bad, frame_len_ok, ovf_evt, wr_en;

    sync_edge_detect u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .hsync   (hsync),
        .vsync   (vsync),
        .pix     ({r, g, b}),
        .pix_d1  (pix_d1),
        .hs_rise (hs_rise),
        .vs_rise (vs_rise)
    );

    // h_cnt/v_cnt describe the current d1 sample; the _q copies hold the
    // previous sample, so at an edge they are the length of what just ended.
    always_comb begin
        h_cnt = h_cnt_q;
        if (hs_rise)
            h_cnt = '0;
        else if (h_cnt_q != HW'(H_TOTAL))
            h_cnt = h_cnt_q + HW'(1);
        v_cnt = v_cnt_q;
        if (vs_rise)
            v_cnt = '0;
        else if (hs_rise && (v_cnt_q != VW'(V_TOTAL)))
            v_cnt = v_cnt_q + VW'(1);
    end

    assign line_bad     = hs_rise && (h_cnt_q != HW'(H_TOTAL - 1));
    assign frame_len_ok = (v_cnt_q == VW'(V_TOTAL - 1));
    assign ovf_evt      = fb_wr_valid && !fb_wr_ready;

    assign wr_en = (state_q == CAPTURE) &&
                   (int'(h_cnt) >= H_START) && (int'(h_cnt) < H_START + H_ACTIVE) &&
                   (int'(v_cnt) >= V_START) && (int'(v_cnt) < V_START + V_ACTIVE);

    always_comb begin
        state_d       = state_q;
        frame_start   = 1'b0;
        line_err_evt  = 1'b0;
        frame_err_evt = 1'b0;
        done_evt      = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable)
                    state_d = SEEK;
            end
            SEEK: begin
                if (vs_rise) begin
                    if (enable) begin
                        state_d     = CAPTURE;
                        frame_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            CAPTURE: begin
                // A bad line abandons the frame; relock on the next vsync.
                if (line_bad) begin
                    line_err_evt = 1'b1;
                    state_d      = SEEK;
                end else if (vs_rise) begin
                    done_evt      = frame_len_ok && !frame_bad_q && !ovf_evt;
                    frame_err_evt = !frame_len_ok;
                    if (enable)
                        frame_start = 1'b1;
                    else
                        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign locked = (state_q == CAPTURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            addr_q      <= '0;
            frame_bad_q <= 1'b0;
            fb_wr_valid <= 1'b0;
            fb_wr_addr  <= '0;
            fb_wr_data  <= '0;
            frame_done  <= 1'b0;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state_q <= state_d;
            h_cnt_q <= h_cnt;
            v_cnt_q <= v_cnt;

            if (frame_start)
                addr_q <= '0;
            else if (wr_en)
                addr_q <= addr_q + ADDR_W'(1);

            if (frame_start)
                frame_bad_q <= 1'b0;
            else if (ovf_evt)
                frame_bad_q <= 1'b1;

            fb_wr_valid <= wr_en;
            if (wr_en) begin
                fb_wr_addr <= addr_q;
                fb_wr_data <= pix_d1;
            end

            frame_done <= done_evt;
            // A new error event outranks a simultaneous clear.
            line_err   <= line_err_evt  | (line_err  & ~err_clr);
            frame_err  <= frame_err_evt | (frame_err & ~err_clr);
            overflow   <= ovf_evt       | (overflow  & ~err_clr);
        end
    end

endmodule

// File: tb/tb_display_capture.sv
module tb_display_capture;

    localparam int H_T   = 20;
    localparam int H_S   = 4;
    localparam int H_A   = 8;
    localparam int V_T   = 10;
    localparam int V_S   = 2;
    localparam int V_A   = 5;
    localparam int AW    = 6;
    localparam int SHORT_LEN = 15;
    localparam int STALL_LEN = 4;
    localparam int FRAME = H_T * V_T;
    localparam int W     = AW + 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          enable = 1'b0;
    logic          err_clr = 1'b0;
    logic          hsync, vsync;
    logic [7:0]    r, g, b;
    logic          fb_wr_valid;
    logic          fb_wr_ready;
    logic [AW-1:0] fb_wr_addr;
    logic [23:0]   fb_wr_data;
    logic          locked, frame_done, line_err, frame_err, overflow;

    int n_chk = 0;
    int n_fail = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    display_capture #(
        .H_TOTAL(H_T), .H_START(H_S), .H_ACTIVE(H_A),
        .V_TOTAL(V_T), .V_START(V_S), .V_ACTIVE(V_A), .ADDR_W(AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .err_clr     (err_clr),
        .hsync       (hsync),
        .vsync       (vsync),
        .r           (r),
        .g           (g),
        .b           (b),
        .fb_wr_valid (fb_wr_valid),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data),
        .locked      (locked),
        .frame_done  (frame_done),
        .line_err    (line_err),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    // ---------------- video source ----------------
    int gen_h = 0;
    int gen_v = 0;
    int gen_frame_cnt = 0;
    int line_len = H_T;
    int short_v = -1;      // line index of the current frame to shorten
    int stall_v = -1;      // line index in which fb_wr_ready is dropped
    int stall_cnt = 0;
    bit short_frame = 1'b0;

    initial begin
        hsync = 1'b0; vsync = 1'b0; r = '0; g = '0; b = '0;
        fb_wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_cnt > 0) begin
                fb_wr_ready = 1'b0;
                stall_cnt--;
            end else begin
                fb_wr_ready = 1'b1;
            end
            if (gen_h == 0 && gen_v == 0) gen_frame_cnt++;
            if (gen_h == 6 && gen_v == stall_v) begin
                stall_cnt = STALL_LEN;
                stall_v = -1;
            end
            hsync = (gen_h < 3);
            vsync = (gen_v == 0);
            r = 8'(gen_v);
            g = 8'(gen_h);
            b = 8'hA5;
            gen_h++;
            if (gen_h >= line_len) begin
                gen_h = 0;
                if (gen_v + 1 >= (short_frame ? V_T - 1 : V_T)) begin
                    gen_v = 0;
                    short_frame = 1'b0;
                end else begin
                    gen_v++;
                end
                if (gen_v == short_v) begin
                    line_len = SHORT_LEN;
                    short_v = -1;
                end else begin
                    line_len = H_T;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int n_acc = 0;
    int n_done = 0;
    int mon_fc = 0;

    initial begin
        logic [W-1:0] exp_w;
        forever begin
            @(posedge clk);
            #1;
            if (gen_frame_cnt != mon_fc) begin
                mon_fc = gen_frame_cnt;
                exp_q.delete();
                for (int a = 0; a < H_A * V_A; a++)
                    exp_q.push_back({AW'(a), 8'(V_S + a / H_A), 8'(H_S + a % H_A), 8'hA5});
            end
            if (fb_wr_valid) begin
                if (fb_wr_ready) n_acc++;
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_extra: got addr %0d data %h, expected no write", fb_wr_addr, fb_wr_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({fb_wr_addr, fb_wr_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL wr_word: got addr %0d data %h, expected addr %0d data %h",
                                 fb_wr_addr, fb_wr_data, exp_w[W-1:24], exp_w[23:0]);
                    end
                end
            end
            if (frame_done) n_done++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string what, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", what, got, exp);
        end
    endtask

    // Returns a few cycles after the source starts a frame, on a negedge.
    task automatic wait_start();
        int c;
        int t;
        c = gen_frame_cnt;
        t = 0;
        while (gen_frame_cnt == c && t < 3 * FRAME) begin
            @(posedge clk);
            t++;
        end
        if (gen_frame_cnt == c) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_start_timeout: got no frame in %0d cycles, expected one", t);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_line(input int v, input int h);
        int t;
        t = 0;
        while (!(gen_v == v && gen_h == h) && t < 3 * FRAME) begin
            @(posedge clk);
            t++;
        end
        if (!(gen_v == v && gen_h == h)) begin
            n_chk++;
            n_fail++;
            $display("FAIL line_timeout: got no line %0d in %0d cycles, expected one", v, t);
        end
    endtask

    task automatic pulse_err_clr();
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
    endtask

    function automatic int out_bits();
        return {24'd0, fb_wr_valid, locked, frame_done, line_err, frame_err, overflow,
                |fb_wr_addr, |fb_wr_data};
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        bit en;
        int short_v;
        int stall_v;
        bit short_frame;
        int acc;
        int done;
        bit le;
        bit fe;
        bit ovf;
        bit lock;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int acc0, done0;
        // en, short_v, stall_v, short_frame | acc, done, le, fe, ovf, lock
        vecs[0] = '{1'b1, -1, -1, 1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b1}; // nominal
        vecs[1] = '{1'b1,  3, -1, 1'b0, 16, 0, 1'b1, 1'b0, 1'b0, 1'b1}; // short line
        vecs[2] = '{1'b1, -1, -1, 1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b1}; // clean after relock
        vecs[3] = '{1'b1, -1,  4, 1'b0, 36, 0, 1'b0, 1'b0, 1'b1, 1'b1}; // backpressure
        vecs[4] = '{1'b1, -1, -1, 1'b1, 40, 0, 1'b0, 1'b1, 1'b0, 1'b1}; // short frame
        vecs[5] = '{1'b1, -1, -1, 1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b0, -1, -1, 1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b0}; // enable drop
        vecs[7] = '{1'b0, -1, -1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0}; // idle
        vecs[8] = '{1'b1, -1, -1, 1'b0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b1}; // seek then lock
        vecs[9] = '{1'b1, -1, -1, 1'b0, 40, 1, 1'b0, 1'b0, 1'b0, 1'b1};

        // reset
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", out_bits(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", out_bits(), 0);
        enable = 1'b1;
        wait_start();

        for (int i = 0; i < 10; i++) begin
            pulse_err_clr();
            enable = vecs[i].en;
            short_v = vecs[i].short_v;
            stall_v = vecs[i].stall_v;
            short_frame = vecs[i].short_frame;
            acc0 = n_acc;
            done0 = n_done;
            wait_start();
            check($sformatf("vec%0d_writes", i), n_acc - acc0, vecs[i].acc);
            check($sformatf("vec%0d_frame_done", i), n_done - done0, vecs[i].done);
            check($sformatf("vec%0d_line_err", i), int'(line_err), int'(vecs[i].le));
            check($sformatf("vec%0d_frame_err", i), int'(frame_err), int'(vecs[i].fe));
            check($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].ovf));
            check($sformatf("vec%0d_locked", i), int'(locked), int'(vecs[i].lock));
        end

        // reset mid-frame with overflow pending, then relock
        pulse_err_clr();
        stall_v = 2;
        wait_line(4, 1);
        @(negedge clk);
        check("ovf_before_rst", int'(overflow), 1);
        rst_n = 1'b0;
        #1 check("rst_mid_outputs", out_bits(), 0);
        repeat (3) @(negedge clk);
        check("rst_hold_outputs", out_bits(), 0);
        rst_n = 1'b1;
        wait_start();
        acc0 = n_acc;
        done0 = n_done;
        wait_start();
        check("relock_writes", n_acc - acc0, 40);
        check("relock_frame_done", n_done - done0, 1);
        check("relock_overflow", int'(overflow), 0);
        check("relock_locked", int'(locked), 1);

        // error event coinciding with err_clr keeps the flag
        pulse_err_clr();
        check("le_before", int'(line_err), 0);
        short_v = 3;
        wait_line(4, 1);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        @(posedge clk);
        #1;
        check("le_same_cycle_clr", int'(line_err), 1);
        check("locked_after_short", int'(locked), 0);
        pulse_err_clr();
        @(posedge clk);
        #1;
        check("le_after_clr", int'(line_err), 0);
        wait_start();
        acc0 = n_acc;
        done0 = n_done;
        wait_start();
        check("after_le_writes", n_acc - acc0, 40);
        check("after_le_frame_done", n_done - done0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #(400 * FRAME * 10);
        n_fail++;
        $display("FAIL watchdog: got no end of test, expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
